mont_exp_ctrl: RTL
==================

MONT_EXP_CTRL -- requirements
Module: mont_exp_ctrl

Interface
REQ-001 The clock and reset SHALL be a single clock `clk` and a synchronous, active-high reset `rst`.
REQ-002 `clk`  in  1  single clock; all state updates on its rising edge.
REQ-003 `rst`  in  1  synchronous reset, active-high.
REQ-004 `start`  in  1  one-cycle request to begin an exponentiation; sampled only in IDLE.
REQ-005 `N_i`  in  256  odd modulus, N > 1.
REQ-006 `Y_i`  in  256  base in Montgomery form: Y*2^256 mod N.
REQ-007 `R_i`  in  256  Montgomery one: 2^256 mod N.
REQ-008 `D_i`  in  256  exponent.
REQ-009 `result_o`  out  256  Y^D mod N, in the normal domain.
REQ-010 `busy_o`  out  1  high from the cycle after an accepted start until `done_o`.
REQ-011 `done_o`  out  1  one-cycle pulse when `result_o` is valid.
REQ-012 `ma_start`  out  1  one-cycle request pulse to the Montgomery multiplier.
REQ-013 `ma_a`, `ma_b`, `ma_n`  out  256 each  multiplier operands A, B and N.
REQ-014 `ma_v`  in  256  multiplier result: A*B*2^-256 mod N.
REQ-015 `ma_finish`  in  1  multiplier completion level; the multiplier holds it low for the start cycle and high once `ma_v` is valid.

Function
REQ-016 On an accepted start, the block SHALL latch `N_i`, `Y_i`, `R_i` and `D_i` into internal registers; input changes after that cycle have no effect.
REQ-017 The block SHALL compute right-to-left binary exponentiation, with m = R and t = Y initially. For bit index i = 0 to 255:
- if D[i] is 1, m = MA(m, t);
- then t = MA(t, t).
REQ-018 After bit 255, the block SHALL perform m = MA(m, 1) to convert m out of the Montgomery domain; `result_o` = m.
REQ-019 States SHALL be IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, NEXT, FIN_REQ, FIN_WAIT and DONE.
REQ-020 State transitions SHALL be:
- IDLE -> MUL_REQ on start when D[0] is 1, otherwise IDLE -> SQR_REQ;
- MUL_REQ -> MUL_WAIT -> SQR_REQ;
- SQR_REQ -> SQR_WAIT -> NEXT;
- NEXT -> FIN_REQ when i = 255; otherwise NEXT increments i and goes to MUL_REQ or SQR_REQ according to D[i+1];
- FIN_REQ -> FIN_WAIT -> DONE -> IDLE.
REQ-021 Each *_REQ state SHALL last exactly one cycle, assert `ma_start` = 1 and drive that step's operands.
REQ-022 Operands SHALL be held stable from the *_REQ cycle until the cycle in which `ma_finish` is sampled high.
REQ-023 A *_WAIT state SHALL exit only on `ma_finish` = 1 sampled at least one cycle after the REQ cycle; in that cycle it SHALL capture `ma_v` into m (MUL, FIN) or t (SQR).
REQ-024 The block SHALL tolerate any multiplier latency of 1 cycle or more.
REQ-025 `ma_n` SHALL always equal the latched N.
REQ-026 The FIN step SHALL drive `ma_b` = 256'd1.
REQ-027 The bit counter SHALL be 8 bits, must not wrap before FIN, and SHALL reach FIN after exactly 256 squarings.
REQ-028 The total number of `ma_start` pulses SHALL be popcount(D) + 257.
REQ-029 In DONE, the block SHALL pulse `done_o` and update `result_o`; `result_o` SHALL hold its value until the next DONE.
REQ-030 `start` asserted while busy SHALL be ignored, with no restart and no re-latch; `start` in the DONE cycle SHALL also be ignored.
REQ-031 `ma_finish` high outside a *_WAIT state SHALL be ignored.
REQ-032 If D = 0, the result SHALL be 1 (m stays R; MA(R, 1) = 1).

Reset
REQ-033 While `rst` = 1 at a clock edge, the block SHALL reset as follows:
- state = IDLE;
- `busy_o` = 0, `done_o` = 0, `ma_start` = 0;
- `result_o` = 0, `ma_a` = 0, `ma_b` = 0, `ma_n` = 0;
- i = 0, m = 0, t = 0.
REQ-034 Reset mid-operation SHALL abort the computation with no `done_o` pulse; a `ma_finish` arriving afterwards SHALL be ignored.
REQ-035 Reset SHALL take priority over `start` in the same cycle.

Verification
REQ-036 The bench SHALL pair the block with a behavioural Montgomery multiplier of configurable latency (1, 3 and 17 cycles) and cover the following scenarios:
- N = 1009, Y = 2 (Y_i = 2*2^256 mod N), D = 10 -> `result_o` = 15, `done_o` pulses once, 259 `ma_start` pulses.
- N = 13, Y = 5, D = 0 -> `result_o` = 1, 257 `ma_start` pulses.
- N = 13, Y = 5, D = 1 -> `result_o` = 5.
- D = all ones with a 256-bit odd N -> result matches a reference model, 513 `ma_start` pulses, operands stable across every WAIT.
- `rst` asserted in SQR_WAIT at i = 100 -> IDLE next cycle, `busy_o` = 0, no `done_o`; a subsequent start with N = 1009, Y = 2, D = 10 -> 15.
- `start` re-pulsed mid-run with different inputs, plus spurious `ma_finish` in MUL_REQ -> both ignored; the original result is unchanged.

Source files
------------

// File: rtl/mont_exp_ctrl.sv
// Purpose: right-to-left modular exponentiation sequencer driving an external Montgomery multiplier.
// Latency: 256 squarings + popcount(D) multiplies + 1 conversion, each REQ + WAIT (+NEXT per bit).
// Backpressure: each multiplier step waits on ma_finish; start is accepted only in IDLE.
module mont_exp_ctrl (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [255:0] N_i,
    input  logic [255:0] Y_i,
    input  logic [255:0] R_i,
    input  logic [255:0] D_i,
    output logic [255:0] result_o,
    output logic         busy_o,
    output logic         done_o,
    output logic         ma_start,
    output logic [255:0] ma_a,
    output logic [255:0] ma_b,
    output logic [255:0] ma_n,
    input  logic [255:0] ma_v,
    input  logic         ma_finish
);

    typedef enum logic [3:0] {
        IDLE, MUL_REQ, MUL_WAIT, SQR_REQ, SQR_WAIT, NEXT, FIN_REQ, FIN_WAIT, DONE
    } state_t;

    state_t       state_q, state_d;
    logic [255:0] n_q, d_q, m_q, t_q, result_q;
    logic [7:0]   i_q;
    logic [7:0]   i_nx;
    logic         accept, cap_m, cap_t, cap_res, adv_i;

    // i never exceeds 255 when incremented, so the 8-bit sum cannot wrap
    assign i_nx     = i_q + 8'd1;
    assign ma_n     = n_q;
    assign result_o = result_q;

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, multiplier request/operands and datapath load enables
    always_comb begin
        state_d  = state_q;
        ma_start = 1'b0;
        ma_a     = '0;
        ma_b     = '0;
        busy_o   = 1'b1;
        done_o   = 1'b0;
        accept   = 1'b0;
        cap_m    = 1'b0;
        cap_t    = 1'b0;
        cap_res  = 1'b0;
        adv_i    = 1'b0;
        case (state_q)
            IDLE: begin
                busy_o = 1'b0;
                if (start) begin
                    accept  = 1'b1;
                    state_d = D_i[0] ? MUL_REQ : SQR_REQ;
                end
            end
            MUL_REQ: begin
                ma_start = 1'b1;
                ma_a     = m_q;
                ma_b     = t_q;
                state_d  = MUL_WAIT;
            end
            MUL_WAIT: begin
                ma_a = m_q;
                ma_b = t_q;
                if (ma_finish) begin
                    cap_m   = 1'b1;
                    state_d = SQR_REQ;
                end
            end
            SQR_REQ: begin
                ma_start = 1'b1;
                ma_a     = t_q;
                ma_b     = t_q;
                state_d  = SQR_WAIT;
            end
            SQR_WAIT: begin
                ma_a = t_q;
                ma_b = t_q;
                if (ma_finish) begin
                    cap_t   = 1'b1;
                    state_d = NEXT;
                end
            end
            NEXT: begin
                if (i_q == 8'd255) begin
                    state_d = FIN_REQ;
                end else begin
                    adv_i   = 1'b1;
                    state_d = d_q[i_nx] ? MUL_REQ : SQR_REQ;
                end
            end
            FIN_REQ: begin
                ma_start = 1'b1;
                ma_a     = m_q;
                ma_b     = 256'd1;
                state_d  = FIN_WAIT;
            end
            FIN_WAIT: begin
                ma_a = m_q;
                ma_b = 256'd1;
                if (ma_finish) begin
                    cap_m   = 1'b1;
                    cap_res = 1'b1;
                    state_d = DONE;
                end
            end
            DONE: begin
                busy_o  = 1'b0;
                done_o  = 1'b1;
                state_d = IDLE;
            end
            default: begin
                busy_o  = 1'b0;
                state_d = IDLE;
            end
        endcase
    end

    // Operand latch, accumulator/square registers, bit counter; result loads on entry to DONE
    always_ff @(posedge clk) begin
        if (rst) begin
            n_q      <= '0;
            d_q      <= '0;
            m_q      <= '0;
            t_q      <= '0;
            i_q      <= '0;
            result_q <= '0;
        end else begin
            if (accept) begin
                n_q <= N_i;
                d_q <= D_i;
                m_q <= R_i;
                t_q <= Y_i;
                i_q <= '0;
            end
            if (cap_m) begin
                m_q <= ma_v;
            end
            if (cap_t) begin
                t_q <= ma_v;
            end
            if (adv_i) begin
                i_q <= i_nx;
            end
            if (cap_res) begin
                result_q <= ma_v;
            end
        end
    end

endmodule
